stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
- Sequences the image datapath through four stages: load into memory, 3x3 convolution on the PE, 2x2 pooling, then display.
- Drives the per-stage hold resets (rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp), the load address, and the convolution and pooling window coordinates.
- Sits above the stage blocks and is started and stopped by the top level with start, abort and done.

Parameters:
IMG_N, 6, input image edge length; must be even and >= 4
PE_LAT, 3, cycles allotted per convolution window; must be >= 1
DISP_CYCLES, 4, cycles spent in the display stage; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  begin a run; sampled in IDLE only
abort  input  1  cancel the run; return to IDLE
in_valid  input  1  load pixel valid
in_ready  output  1  sequencer accepting load pixels
mem_we  output  1  memory write strobe; equals in_valid & in_ready
mem_addr  output  clog2(IMG_N*IMG_N)  load write address
rst_mem  output  1  memory hold reset, 1 = held
rst_pe  output  1  PE hold reset, 1 = held
rst_3b3  output  1  3x3 window buffer hold reset, 1 = held
rst_2b2  output  1  2x2 pool hold reset, 1 = held
rst_disp  output  1  display hold reset, 1 = held
win_start  output  1  one-cycle pulse at the first cycle of each convolution window
conv_row  output  clog2(IMG_N)  convolution window origin row
conv_col  output  clog2(IMG_N)  convolution window origin column
pool_valid  output  1  pool window valid, one cycle per window
pool_row  output  clog2(IMG_N)  pool window origin row, step 2
pool_col  output  clog2(IMG_N)  pool window origin column, step 2
busy  output  1  state is not IDLE
done  output  1  one-cycle pulse on run completion

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all rst_* = 1; all counters, coordinates and strobes = 0; busy=0; done=0.
- All outputs are registered, except mem_we, which is combinational.
- States: IDLE, LOAD, CONV, POOL, DISP, FIN.
- IDLE:
  - start=1 -> LOAD on the next edge; all counters cleared.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - Each in_valid & in_ready cycle writes mem_addr, then increments mem_addr.
  - Accepting address IMG_N*IMG_N-1 -> CONV; in_ready drops on the same edge.
  - Gaps with in_valid=0 hold mem_addr.
- CONV:
  - Origins scan row-major, rows and columns each 0..IMG_N-3.
  - Each window lasts PE_LAT cycles; win_start is high in the first of them.
  - After the last cycle of window (IMG_N-3, IMG_N-3) -> POOL.
  - Total CONV duration = (IMG_N-2)^2 * PE_LAT cycles.
- POOL:
  - Origins scan row-major in steps of 2 over 0..IMG_N-4.
  - pool_valid=1 every cycle, one window per cycle.
  - Total POOL duration = ((IMG_N-2)/2)^2 cycles, then -> DISP.
- DISP: lasts DISP_CYCLES cycles, then -> FIN.
- FIN: done=1 for one cycle, then -> IDLE.
- Hold-reset release windows (0 = released):
  - rst_mem: LOAD through FIN.
  - rst_pe, rst_3b3: CONV and POOL.
  - rst_2b2: POOL and DISP.
  - rst_disp: DISP and FIN.
  - Every rst_* is 1 in IDLE.
- abort:
  - In any non-IDLE state, abort -> IDLE on the next edge.
  - All rst_* = 1, counters cleared, no done pulse.
  - abort takes priority over every transition in the same cycle.
  - abort in IDLE has no effect; if start and abort are high together in IDLE, start is ignored.
- Coordinates and mem_addr hold their last value between their active states; they are cleared on a new run and on abort.
- Reset asserted mid-run: same end result as abort, but asynchronous.

Optional Feature:
- Macro: SEQ_CYCLE_COUNT_EN.
- Defined:
  - Adds output run_cycles, 32 bits.
  - Counts every cycle with busy=1; cleared on start acceptance.
  - Frozen at FIN so it holds the run length; cleared on abort and reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with defaults -> all rst_*=1, busy=0, done=0, in_ready=0.
- start, then 36 contiguous in_valid -> mem_addr 0..35 with mem_we high each cycle; CONV entered on the edge after address 35; rst_mem=0 from LOAD entry.
- CONV -> 16 win_start pulses spaced 3 cycles apart; origins (0,0),(0,1)..(3,3); exactly 48 cycles; rst_pe=rst_3b3=0 throughout.
- POOL then DISP -> 4 pool_valid cycles with origins (0,0),(0,2),(2,0),(2,2); then 4 DISP cycles; done pulses once; IDLE with all rst_*=1.
- Load with in_valid gaps (1,0,0,1,...) -> mem_addr holds during gaps; exactly 36 writes; start pulsed mid-run is ignored.
- abort during CONV at window 5 -> IDLE next edge, all rst_*=1, no done; a following start runs cleanly; with SEQ_CYCLE_COUNT_EN and a gap-free load, run_cycles = 36+48+4+4+1 = 93.

Source files
------------

// File: rtl/stage_sequencer.sv
// Stage sequencer: walks the image datapath through load, 3x3 conv, 2x2 pool and display.
// Define SEQ_CYCLE_COUNT_EN to add the 32-bit run_cycles busy-cycle counter output.
module stage_sequencer #(
    parameter int IMG_N       = 6,
    parameter int PE_LAT      = 3,
    parameter int DISP_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              mem_we,
    output logic [$clog2(IMG_N*IMG_N)-1:0]    mem_addr,
    output logic                              rst_mem,
    output logic                              rst_pe,
    output logic                              rst_3b3,
    output logic                              rst_2b2,
    output logic                              rst_disp,
    output logic                              win_start,
    output logic [$clog2(IMG_N)-1:0]          conv_row,
    output logic [$clog2(IMG_N)-1:0]          conv_col,
    output logic                              pool_valid,
    output logic [$clog2(IMG_N)-1:0]          pool_row,
    output logic [$clog2(IMG_N)-1:0]          pool_col,
    output logic                              busy,
    output logic                              done
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    output logic [31:0]                       run_cycles
`endif
);

    localparam int AW = $clog2(IMG_N*IMG_N);
    localparam int CW = $clog2(IMG_N);
    localparam int LW = $clog2(PE_LAT+1);
    localparam int DW = $clog2(DISP_CYCLES+1);

    localparam logic [AW-1:0] ADDR_LAST = AW'(IMG_N*IMG_N-1);
    localparam logic [CW-1:0] CONV_LAST = CW'(IMG_N-3);
    localparam logic [CW-1:0] POOL_LAST = CW'(IMG_N-4);
    localparam logic [LW-1:0] LAT_LAST  = LW'(PE_LAT-1);
    localparam logic [DW-1:0] DISP_LAST = DW'(DISP_CYCLES-1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_POOL, S_DISP, S_FIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [DW-1:0]   disp_q, disp_d;
    logic [CW-1:0]   crow_d, ccol_d, prow_d, pcol_d;
    logic            win_start_d, pool_valid_d, done_d;

    assign mem_we = in_valid & in_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
        state_d      = state_q;
        addr_d       = mem_addr;
        lat_d        = lat_q;
        disp_d       = disp_q;
        crow_d       = conv_row;
        ccol_d       = conv_col;
        prow_d       = pool_row;
        pcol_d       = pool_col;
        win_start_d  = 1'b0;
        pool_valid_d = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            S_IDLE: if (start && !abort) begin
                state_d = S_LOAD;
                addr_d  = '0;
                lat_d   = '0;
                disp_d  = '0;
                crow_d  = '0;
                ccol_d  = '0;
                prow_d  = '0;
                pcol_d  = '0;
            end
            S_LOAD: if (mem_we) begin
                // The last address is held rather than wrapped so it stays in range.
                if (mem_addr == ADDR_LAST) begin
                    state_d     = S_CONV;
                    win_start_d = 1'b1;
                end else begin
                    addr_d = mem_addr + AW'(1);
                end
            end
            S_CONV: begin
                if (lat_q == LAT_LAST) begin
                    lat_d = '0;
                    if (conv_col == CONV_LAST) begin
                        if (conv_row == CONV_LAST) begin
                            state_d      = S_POOL;
                            pool_valid_d = 1'b1;
                        end else begin
                            crow_d      = conv_row + CW'(1);
                            ccol_d      = '0;
                            win_start_d = 1'b1;
                        end
                    end else begin
                        ccol_d      = conv_col + CW'(1);
                        win_start_d = 1'b1;
                    end
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_POOL: begin
                if (pool_col == POOL_LAST) begin
                    if (pool_row == POOL_LAST) begin
                        state_d = S_DISP;
                    end else begin
                        prow_d       = pool_row + CW'(2);
                        pcol_d       = '0;
                        pool_valid_d = 1'b1;
                    end
                end else begin
                    pcol_d       = pool_col + CW'(2);
                    pool_valid_d = 1'b1;
                end
            end
            S_DISP: begin
                if (disp_q == DISP_LAST) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    disp_d = disp_q + DW'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over every transition above, but only once a run is under way.
        if (abort && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            addr_d       = '0;
            lat_d        = '0;
            disp_d       = '0;
            crow_d       = '0;
            ccol_d       = '0;
            prow_d       = '0;
            pcol_d       = '0;
            win_start_d  = 1'b0;
            pool_valid_d = 1'b0;
            done_d       = 1'b0;
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mem_addr   <= '0;
            lat_q      <= '0;
            disp_q     <= '0;
            conv_row   <= '0;
            conv_col   <= '0;
            pool_row   <= '0;
            pool_col   <= '0;
            win_start  <= 1'b0;
            pool_valid <= 1'b0;
            done       <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            rst_mem    <= 1'b1;
            rst_pe     <= 1'b1;
            rst_3b3    <= 1'b1;
            rst_2b2    <= 1'b1;
            rst_disp   <= 1'b1;
        end else begin
            state_q    <= state_d;
            mem_addr   <= addr_d;
            lat_q      <= lat_d;
            disp_q     <= disp_d;
            conv_row   <= crow_d;
            conv_col   <= ccol_d;
            pool_row   <= prow_d;
            pool_col   <= pcol_d;
            win_start  <= win_start_d;
            pool_valid <= pool_valid_d;
            done       <= done_d;
            // Stage enables are decoded from the next state so they line up with the state register.
            in_ready   <= (state_d == S_LOAD);
            busy       <= (state_d != S_IDLE);
            rst_mem    <= (state_d == S_IDLE);
            rst_pe     <= !(state_d == S_CONV || state_d == S_POOL);
            rst_3b3    <= !(state_d == S_CONV || state_d == S_POOL);
            rst_2b2    <= !(state_d == S_POOL || state_d == S_DISP);
            rst_disp   <= !(state_d == S_DISP || state_d == S_FIN);
        end
    end

`ifdef SEQ_CYCLE_COUNT_EN
    logic [31:0] cyc_d;

    always_comb begin
        cyc_d = run_cycles;
        if (state_q == S_IDLE) begin
            if (start && !abort) cyc_d = '0;
        end else if (abort) begin
            cyc_d = '0;
        end else begin
            cyc_d = run_cycles + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_cycles <= '0;
        else      run_cycles <= cyc_d;
    end
`endif

endmodule
